// File: rtl/line_feeder.sv
// line_feeder: turns a row-major pixel stream into vertical columns of
// HEIGHT_NB pixels (the current pixel plus the pixels directly above it).
// The previous HEIGHT_NB-1 lines are kept in small line memories that shift
// one line upwards on every accepted beat. A single output register with
// valid/ready sits on the downstream side.
module line_feeder #(
  parameter int HEIGHT_NB = 3,
  parameter int IMG_WIDTH = 8,
  parameter int LINE_LEN  = 64,
  parameter int LINE_AW   = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [IMG_WIDTH-1:0]           up_pix,
  input  logic                           up_sof,
  input  logic                           up_val,
  output logic                           up_rdy,
  output logic [HEIGHT_NB*IMG_WIDTH-1:0] dn_img,
  output logic                           dn_val,
  input  logic                           dn_rdy
);

  localparam int ROW_W = (HEIGHT_NB > 2) ? $clog2(HEIGHT_NB) : 1;
  localparam logic [ROW_W-1:0]   ROW_MAX  = ROW_W'(HEIGHT_NB - 1);
  localparam logic [LINE_AW-1:0] COL_LAST = LINE_AW'(LINE_LEN - 1);

  typedef enum logic [0:0] {
    ST_FILL   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t                         state_q, state_d, eff_state_s;
  logic [LINE_AW-1:0]             col_q, col_d, eff_col_s;
  logic [ROW_W-1:0]               row_q, row_d, eff_row_s;
  logic                           dn_val_q, dn_val_d;
  logic [HEIGHT_NB*IMG_WIDTH-1:0] dn_img_q, dn_img_d;
  logic                           accept_s;
  logic                           wrap_s;

  // Line memories: index 0 is the oldest line. Not reset; FILL gating
  // guarantees nothing stale is ever emitted.
  logic [IMG_WIDTH-1:0] mem_q [0:HEIGHT_NB-2][0:LINE_LEN-1];

  // Column taps: entries 0..HEIGHT_NB-2 come from memory, the top entry is
  // the incoming pixel. Entry k+1 is also the write data for line k.
  logic [IMG_WIDTH-1:0] tap_s [0:HEIGHT_NB-1];

  // Single output register without skid, so readiness follows dn_rdy directly.
  assign up_rdy   = ~rst & (~dn_val_q | dn_rdy);
  assign accept_s = up_val & up_rdy;
  assign dn_val   = dn_val_q;
  assign dn_img   = dn_img_q;

  // A sof beat is treated as col 0 / row 0 of a fresh frame, whatever the count.
  always_comb begin
    eff_col_s   = col_q;
    eff_row_s   = row_q;
    eff_state_s = state_q;
    if (up_sof) begin
      eff_col_s   = {LINE_AW{1'b0}};
      eff_row_s   = {ROW_W{1'b0}};
      eff_state_s = ST_FILL;
    end else begin
      eff_col_s   = col_q;
      eff_row_s   = row_q;
      eff_state_s = state_q;
    end
  end

  // Read the column above the current pixel (read-before-write).
  always_comb begin
    for (int k = 0; k < HEIGHT_NB - 1; k++) begin
      tap_s[k] = mem_q[k][eff_col_s];
    end
    tap_s[HEIGHT_NB-1] = up_pix;
  end

  // Column/row counters and FILL/STREAM sequencing.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    wrap_s  = 1'b0;
    if (accept_s) begin
      wrap_s = (eff_col_s == COL_LAST);
      if (wrap_s) begin
        col_d = {LINE_AW{1'b0}};
      end else begin
        col_d = eff_col_s + LINE_AW'(1);
      end
      if (wrap_s && (eff_row_s != ROW_MAX)) begin
        row_d = eff_row_s + ROW_W'(1);
      end else begin
        row_d = eff_row_s;
      end
      case (eff_state_s)
        ST_FILL: begin
          if (wrap_s && (eff_row_s == ROW_MAX - ROW_W'(1))) begin
            state_d = ST_STREAM;
          end else begin
            state_d = ST_FILL;
          end
        end
        ST_STREAM: state_d = ST_STREAM;
        default:   state_d = ST_FILL;
      endcase
    end else begin
      col_d   = col_q;
      row_d   = row_q;
      state_d = state_q;
    end
  end

  // Output register: load on a STREAM beat, drain on ready, otherwise hold.
  always_comb begin
    dn_val_d = dn_val_q;
    dn_img_d = dn_img_q;
    if (accept_s && (eff_state_s == ST_STREAM)) begin
      dn_val_d = 1'b1;
      for (int h = 0; h < HEIGHT_NB; h++) begin
        dn_img_d[h*IMG_WIDTH +: IMG_WIDTH] = tap_s[h];
      end
    end else if (dn_rdy) begin
      dn_val_d = 1'b0;
    end else begin
      dn_val_d = dn_val_q;
    end
  end

  // Control and output state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FILL;
      col_q    <= {LINE_AW{1'b0}};
      row_q    <= {ROW_W{1'b0}};
      dn_val_q <= 1'b0;
      dn_img_q <= {(HEIGHT_NB*IMG_WIDTH){1'b0}};
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      dn_val_q <= dn_val_d;
      dn_img_q <= dn_img_d;
    end
  end

  // Shift the column up one line: each line takes the one below, newest takes up_pix.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      for (int k = 0; k < HEIGHT_NB - 1; k++) begin
        mem_q[k][eff_col_s] <= tap_s[k+1];
      end
    end
  end

endmodule

// File: tb/tb_line_feeder.sv
// Directed bench for line_feeder with HEIGHT_NB=3, LINE_LEN=4, IMG_WIDTH=8.
module tb_line_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  up_pix;
  logic        up_sof;
  logic        up_val;
  logic        up_rdy;
  logic [23:0] dn_img;
  logic        dn_val;
  logic        dn_rdy;

  int checks   = 0;
  int failures = 0;

  line_feeder #(
    .HEIGHT_NB(3),
    .IMG_WIDTH(8),
    .LINE_LEN (4),
    .LINE_AW  (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .up_pix(up_pix),
    .up_sof(up_sof),
    .up_val(up_val),
    .up_rdy(up_rdy),
    .dn_img(dn_img),
    .dn_val(dn_val),
    .dn_rdy(dn_rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] col3(input int top, input int mid, input int bot);
    logic [31:0] a, b, c;
    a = top; b = mid; c = bot;
    col3 = {a[7:0], b[7:0], c[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int pix, input logic sof);
    logic [31:0] v;
    v      = pix;
    up_pix = v[7:0];
    up_sof = sof;
    up_val = 1'b1;
    step();
  endtask

  logic [23:0] exp_q[$];
  int          outs;
  int          idx;
  logic        acc;

  initial begin
    rst = 1'b1; up_pix = 8'd0; up_sof = 1'b0; up_val = 1'b0; dn_rdy = 1'b1;
    step(); step();
    chk("rst_up_rdy", 32'(up_rdy), 32'd0);
    chk("rst_dn_val", 32'(dn_val), 32'd0);
    chk("rst_dn_img", 32'(dn_img), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_up_rdy", 32'(up_rdy), 32'd1);

    // Test 1: one gapless frame.
    outs = 0;
    for (int p = 0; p < 16; p++) begin
      beat(p, p == 0);
      if (p < 8) begin
        chk("t1_fill_val", 32'(dn_val), 32'd0);
      end else begin
        chk("t1_val", 32'(dn_val), 32'd1);
        chk("t1_img", 32'(dn_img), 32'(col3(p, p - 4, p - 8)));
        outs++;
      end
    end
    up_val = 1'b0;
    step();
    chk("t1_drain", 32'(dn_val), 32'd0);
    chk("t1_count", 32'(outs), 32'd8);

    // Test 2: downstream stall after the first output.
    for (int p = 0; p < 9; p++) beat(p, p == 0);
    chk("t2_first", 32'(dn_img), 32'(col3(8, 4, 0)));
    up_pix = 8'd9; up_sof = 1'b0; up_val = 1'b1; dn_rdy = 1'b0;
    #1;
    chk("t2_up_rdy_low", 32'(up_rdy), 32'd0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t2_hold_val", 32'(dn_val), 32'd1);
      chk("t2_hold_img", 32'(dn_img), 32'(col3(8, 4, 0)));
      chk("t2_hold_rdy", 32'(up_rdy), 32'd0);
    end
    dn_rdy = 1'b1;
    for (int p = 9; p < 16; p++) begin
      beat(p, 1'b0);
      chk("t2_val", 32'(dn_val), 32'd1);
      chk("t2_img", 32'(dn_img), 32'(col3(p, p - 4, p - 8)));
    end
    up_val = 1'b0;
    step();
    chk("t2_drain", 32'(dn_val), 32'd0);

    // Test 4: sof arrives mid-line while streaming.
    for (int p = 0; p < 10; p++) beat(p, p == 0);
    chk("t4_pre_img", 32'(dn_img), 32'(col3(9, 5, 1)));
    for (int n = 0; n < 8; n++) begin
      beat(100 + n, n == 0);
      chk("t4_fill_val", 32'(dn_val), 32'd0);
    end
    beat(108, 1'b0);
    chk("t4_val", 32'(dn_val), 32'd1);
    chk("t4_img", 32'(dn_img), 32'(col3(108, 104, 100)));

    // Test 5: reset while an output is pending.
    beat(109, 1'b0);
    chk("t5_pre_val", 32'(dn_val), 32'd1);
    chk("t5_pre_img", 32'(dn_img), 32'(col3(109, 105, 101)));
    rst = 1'b1;
    #1;
    chk("t5_rst_val", 32'(dn_val), 32'd0);
    chk("t5_rst_rdy", 32'(up_rdy), 32'd0);
    chk("t5_rst_img", 32'(dn_img), 32'd0);
    step();
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      beat(200 + n, 1'b0);
      chk("t5_fill_val", 32'(dn_val), 32'd0);
    end
    beat(208, 1'b0);
    chk("t5_val", 32'(dn_val), 32'd1);
    chk("t5_img", 32'(dn_img), 32'(col3(208, 204, 200)));
    up_val = 1'b0;
    step();

    // Test 3: three 6-line frames with random up_val gaps.
    for (int f = 0; f < 3; f++) begin
      for (int p = 8; p < 24; p++) exp_q.push_back(col3(p + f*30, p - 4 + f*30, p - 8 + f*30));
    end
    idx = 0;
    for (int cyc = 0; cyc < 1000 && (idx < 72 || dn_val); cyc++) begin
      up_val = (idx < 72) ? 1'($urandom_range(0, 1)) : 1'b0;
      up_pix = 8'((idx % 24) + (idx / 24) * 30);
      up_sof = ((idx % 24) == 0);
      #0;
      acc = up_val & up_rdy;
      step();
      if (acc) idx++;
      if (dn_val) begin
        if (exp_q.size() == 0) chk("t3_extra", 32'd1, 32'd0);
        else chk("t3_img", 32'(dn_img), 32'(exp_q.pop_front()));
      end
    end
    chk("t3_beats", 32'(idx), 32'd72);
    chk("t3_left", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
